// File: rtl/rca_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states and
// the counter sizing helper.
package rca_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rca4_slice.sv
// Combinational 4-bit ripple-carry slice; also exposes the carry into bit 3
// so the caller can derive signed overflow on the final nibble.
module rca4_slice
  import rca_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                c3
);

  logic [NIBBLE_W:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = w_c[NIBBLE_W];
  assign c3 = w_c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder/subtractor that feeds one nibble per clock through a 4-bit RCA
// slice, LSB first, with valid/ready handshakes on both sides.
module nibble_serial_adder
  import rca_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLES*NIBBLE_W-1:0] a,
  input  logic [NIBBLES*NIBBLE_W-1:0] b,
  input  logic                      cin,
  input  logic                      sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLES*NIBBLE_W-1:0] sum,
  output logic                      cout,
  output logic                      ovf
);

  localparam int W     = NIBBLES * NIBBLE_W;
  localparam int CNT_W = clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [NIBBLE_W-1:0] w_s;
  logic                w_co;
  logic                w_c3;

  rca4_slice u_slice (
    .a  (r_a[NIBBLE_W-1:0]),
    .b  (r_b[NIBBLE_W-1:0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co),
    .c3 (w_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Subtraction is a + ~b + 1: invert b once here, seed the carry with 1.
          if (in_valid) begin
            r_a        <= a;
            r_b        <= sub ? ~b : b;
            r_carry    <= sub ? 1'b1 : cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_sum   <= {w_s, r_sum[W-1:NIBBLE_W]};
          r_carry <= w_co;
          r_a     <= r_a >> NIBBLE_W;
          r_b     <= r_b >> NIBBLE_W;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_cout      <= w_co;
            r_ovf       <= w_co ^ w_c3;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vectors and corner sequences on a
// 4-nibble instance, randomized regression on 2- and 8-nibble instances.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance index 0: NIBBLES=2, 1: NIBBLES=4, 2: NIBBLES=8
  logic [2:0]  in_valid  = '0;
  logic [2:0]  cin       = '0;
  logic [2:0]  sub       = '0;
  logic [2:0]  out_ready = '0;
  logic [31:0] a_d [3];
  logic [31:0] b_d [3];

  logic ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
  logic [7:0]  s0;
  logic [15:0] s1;
  logic [31:0] s2;

  nibble_serial_adder #(.NIBBLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir0),
    .a(a_d[0][7:0]), .b(b_d[0][7:0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(ov0), .out_ready(out_ready[0]), .sum(s0), .cout(co0), .ovf(of0));

  nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir1),
    .a(a_d[1][15:0]), .b(b_d[1][15:0]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(ov1), .out_ready(out_ready[1]), .sum(s1), .cout(co1), .ovf(of1));

  nibble_serial_adder #(.NIBBLES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir2),
    .a(a_d[2]), .b(b_d[2]), .cin(cin[2]), .sub(sub[2]),
    .out_valid(ov2), .out_ready(out_ready[2]), .sum(s2), .cout(co2), .ovf(of2));

  int errors = 0;
  int checks = 0;

  function automatic int nib(input int idx);
    return (idx == 0) ? 2 : (idx == 1) ? 4 : 8;
  endfunction
  function automatic logic g_ready(input int idx);
    return (idx == 0) ? ir0 : (idx == 1) ? ir1 : ir2;
  endfunction
  function automatic logic g_valid(input int idx);
    return (idx == 0) ? ov0 : (idx == 1) ? ov1 : ov2;
  endfunction
  function automatic logic g_cout(input int idx);
    return (idx == 0) ? co0 : (idx == 1) ? co1 : co2;
  endfunction
  function automatic logic g_ovf(input int idx);
    return (idx == 0) ? of0 : (idx == 1) ? of1 : of2;
  endfunction
  function automatic logic [63:0] g_sum(input int idx);
    return (idx == 0) ? {56'd0, s0} : (idx == 1) ? {48'd0, s1} : {32'd0, s2};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic plus signed-range overflow rule.
  function automatic void ref_model(input int n, input logic [63:0] ai, input logic [63:0] bi,
                                    input logic ci, input logic sb,
                                    output logic [63:0] s, output logic co, output logic ov);
    int w;
    logic [63:0] mask, av, bv;
    longint sa, sbv, res;
    w    = 4 * n;
    mask = (64'd1 << w) - 64'd1;
    av   = ai & mask;
    bv   = bi & mask;
    sa   = av[w-1] ? longint'(av) - (longint'(1) <<< w) : longint'(av);
    sbv  = bv[w-1] ? longint'(bv) - (longint'(1) <<< w) : longint'(bv);
    if (sb) begin
      s   = (av - bv) & mask;
      co  = (av >= bv);
      res = sa - sbv;
    end else begin
      s   = (av + bv + 64'(ci)) & mask;
      co  = ((av + bv + 64'(ci)) >> w) != 0;
      res = sa + sbv + longint'(ci);
    end
    ov = (res > ((longint'(1) <<< (w - 1)) - 1)) || (res < -(longint'(1) <<< (w - 1)));
  endfunction

  task automatic run_op(input int idx, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic sb, input int stall, input logic hold_valid,
                        input logic [63:0] es, input logic ec, input logic eo);
    int n, waitc, lat;
    n = nib(idx);
    waitc = 0;
    @(negedge clk);
    while (!g_ready(idx) && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!g_ready(idx)) begin
      check("in_ready_timeout", 64'(g_ready(idx)), 64'd1);
      return;
    end
    a_d[idx] = av; b_d[idx] = bv; cin[idx] = ci; sub[idx] = sb; in_valid[idx] = 1'b1;
    @(posedge clk); #1;
    if (!hold_valid) begin
      in_valid[idx] = 1'b0;
      a_d[idx] = $urandom; b_d[idx] = $urandom; cin[idx] = 1'($urandom); sub[idx] = 1'($urandom);
    end
    out_ready[idx] = (stall == 0);
    lat = 0;
    while (!g_valid(idx) && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat < n) check("in_ready_run", 64'(g_ready(idx)), 64'd0);
    end
    if (!g_valid(idx)) begin
      check("out_valid_timeout", 64'(g_valid(idx)), 64'd1);
      out_ready[idx] = 1'b0;
      in_valid[idx] = 1'b0;
      return;
    end
    check("latency", 64'(lat), 64'(n));
    check("sum", g_sum(idx), es);
    check("cout", 64'(g_cout(idx)), 64'(ec));
    check("ovf", 64'(g_ovf(idx)), 64'(eo));
    check("in_ready_done", 64'(g_ready(idx)), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(g_valid(idx)), 64'd1);
      check("stall_sum", g_sum(idx), es);
      check("stall_flags", {62'd0, g_cout(idx), g_ovf(idx)}, {62'd0, ec, eo});
      check("stall_in_ready", 64'(g_ready(idx)), 64'd0);
    end
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
    check("post_hs_valid", 64'(g_valid(idx)), 64'd0);
    check("post_hs_in_ready", 64'(g_ready(idx)), 64'd1);
    in_valid[idx] = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        ci, sb;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  initial begin
    vec_t vecs [6];
    logic [63:0] es;
    logic ec, eo;
    logic [31:0] ra, rb;
    logic rc, rs;
    int   ids [2];

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin a_d[i] = '0; b_d[i] = '0; end

    #12;
    check("rst_in_ready", {61'd0, ir0, ir1, ir2}, 64'd7);
    check("rst_out_valid", {61'd0, ov0, ov1, ov2}, 64'd0);
    check("rst_sum", g_sum(1), 64'd0);
    check("rst_flags", {62'd0, co1, of1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(1, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].ci, vecs[i].sb, 0, 1'b0,
             64'(vecs[i].s), vecs[i].co, vecs[i].ov);

    // Back-pressure: 3 stalled DONE cycles with in_valid held high
    run_op(1, 32'h00F0, 32'h0F10, 1'b0, 1'b0, 3, 1'b1, 64'h1000, 1'b0, 1'b0);

    // Reset two nibbles into RUN, then a clean 1+1
    @(negedge clk);
    a_d[1] = 32'hFFFF; b_d[1] = 32'hFFFF; cin[1] = 1'b1; sub[1] = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", 64'(ir1), 64'd1);
    check("midrun_rst_out_valid", 64'(ov1), 64'd0);
    check("midrun_rst_sum", g_sum(1), 64'd0);
    check("midrun_rst_flags", {62'd0, co1, of1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 32'h0001, 32'h0001, 1'b0, 1'b0, 0, 1'b0, 64'h0002, 1'b0, 1'b0);

    ids[0] = 0;
    ids[1] = 2;
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 40; t++) begin
        ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
        if (t < 4) begin
          ra = (t[0]) ? 32'hFFFFFFFF : 32'h7FFFFFFF;
          rb = (t[1]) ? 32'h00000001 : 32'h80000000;
        end
        ref_model(nib(ids[k]), 64'(ra), 64'(rb), rc, rs, es, ec, eo);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        run_op(ids[k], ra, rb, rc, rs, int'($urandom_range(0, 3)), 1'b0, es, ec, eo);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
